// File: rtl/memd_responder_pkg.sv
// Shared ISA memory parameters and types for the data-memory responder.
// Sizes here must track the ISA reference model's memd definition.
package memd_responder_pkg;

    localparam int REG_LEN       = 32;
    localparam int MEMD_SIZE     = 16;
    localparam int MEMD_SIZE_LOG = 4;

    typedef logic [REG_LEN-1:0]       reg_t;
    typedef logic [MEMD_SIZE_LOG-1:0] memd_addr_t;

endpackage

// File: rtl/memd_resp_fifo.sv
// Synchronous FIFO holding completed load responses until the consumer takes them.
// Push and pop in the same cycle are both honoured, including when full.
module memd_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/memd_responder.sv
// Data-memory responder: owns memd, serves in-order loads after a fixed latency.
// Define MEMD_INIT_CUSTOMIZED_EN to reset memd[0] to 1 instead of 0.
module memd_responder
    import memd_responder_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MEMD_SIZE_LOG-1:0] req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [REG_LEN-1:0]       resp_data,
    input  logic                     wr_en,
    input  logic [MEMD_SIZE_LOG-1:0] wr_addr,
    input  logic [REG_LEN-1:0]       wr_data
);

    localparam int               CNT_W      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(QUEUE_DEPTH);

`ifdef MEMD_INIT_CUSTOMIZED_EN
    localparam reg_t ENTRY0_INIT = reg_t'(1);
`else
    localparam reg_t ENTRY0_INIT = '0;
`endif

    reg_t             memd [MEMD_SIZE];
    reg_t             read_data;
    logic             accept;
    logic             pop;
    logic             push_valid;
    reg_t             push_data;
    logic [CNT_W-1:0] outstanding;
    logic             fifo_empty;
    logic             fifo_full;
    reg_t             fifo_head;

    assign accept     = req_valid && req_ready;
    assign read_data  = memd[req_addr];
    assign req_ready  = rst && (outstanding < CREDIT_MAX);
    assign resp_valid = rst && !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = resp_valid ? fifo_head : '0;

    // The load captures read_data at the same edge that applies a write, so a
    // same-address load in that cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MEMD_SIZE; i++) begin
                memd[i] <= (i == 0) ? ENTRY0_INIT : '0;
            end
        end else if (wr_en) begin
            memd[wr_addr] <= wr_data;
        end
    end

    // Stage 0 is the array read in the accept cycle itself; the remaining
    // LATENCY-1 stages are registers, and the FIFO write adds the last cycle.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign push_valid = accept;
            assign push_data  = read_data;
        end else begin : g_pipe
            logic pipe_valid [LATENCY-1];
            reg_t pipe_data  [LATENCY-1];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pipe_valid[i] <= 1'b0;
                    end
                end else begin
                    pipe_valid[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pipe_data[0] <= read_data;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end

            assign push_valid = pipe_valid[LATENCY-2];
            assign push_data  = pipe_data[LATENCY-2];
        end
    endgenerate

    // Credits cover both the pipeline and the FIFO, so the pipeline never stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (pop && !accept) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    memd_resp_fifo #(
        .WIDTH (REG_LEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    credit_no_overflow: assert property (
        @(posedge clk) disable iff (!rst) (push_valid && !pop) |-> !fifo_full
    );

endmodule

// File: tb/tb_memd_responder.sv
// Scoreboard bench for memd_responder with LATENCY=2, QUEUE_DEPTH=4.
// Honours MEMD_INIT_CUSTOMIZED_EN for the expected reset contents of memd[0].
module tb_memd_responder;
    import memd_responder_pkg::*;

    localparam int LATENCY     = 2;
    localparam int QUEUE_DEPTH = 4;

`ifdef MEMD_INIT_CUSTOMIZED_EN
    localparam reg_t ADDR0_INIT = 32'd1;
`else
    localparam reg_t ADDR0_INIT = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    memd_addr_t req_addr;
    logic       resp_valid;
    logic       resp_ready;
    reg_t       resp_data;
    logic       wr_en;
    memd_addr_t wr_addr;
    reg_t       wr_data;

    int   tests_run    = 0;
    int   tests_failed = 0;
    reg_t model_mem [MEMD_SIZE];
    reg_t exp_q [$];

    logic acc;
    logic rdy;
    logic popd;
    logic rvld;
    reg_t rd;

    memd_responder #(
        .LATENCY     (LATENCY),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < MEMD_SIZE; i++) begin
            model_mem[i] = '0;
        end
        model_mem[0] = ADDR0_INIT;
        exp_q.delete();
    endtask

    // One clock cycle: drive, sample mid-cycle, update the model at the edge.
    task automatic drive_cycle(input logic r, input logic rv, input memd_addr_t ra,
                               input logic rr, input logic we, input memd_addr_t wa,
                               input reg_t wd);
        rst        = r;
        req_valid  = rv;
        req_addr   = ra;
        resp_ready = rr;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        @(negedge clk);
        rdy  = req_ready;
        rvld = resp_valid;
        rd   = resp_data;
        acc  = req_valid && req_ready;
        popd = resp_valid && resp_ready;
        if (acc) begin
            exp_q.push_back(model_mem[ra]);
        end
        if (we && r) begin
            model_mem[wa] = wd;
        end
        @(posedge clk);
        if (!r) begin
            model_reset();
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
            tests_run++;
            if (rdy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_req_ready: got %0b, expected 0", rdy);
            end
            tests_run++;
            if (rvld !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_resp_valid: got %0b, expected 0", rvld);
            end
            tests_run++;
            if (rd !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_resp_data: got %0h, expected 0", rd);
            end
            tests_run++;
            if (acc !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_accept: got %0b, expected 0", acc);
            end
        end
        drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_single_load();
        int   lat   = 0;
        logic found = 1'b0;
        reg_t exp;
        drive_cycle(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
        tests_run++;
        if (acc !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_accept: got %0b, expected 1", acc);
        end
        for (int i = 1; i <= 10 && !found; i++) begin
            drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
            if (rvld) begin
                found = 1'b1;
                lat   = i;
                exp   = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                tests_run++;
                if (rd !== exp || rd !== ADDR0_INIT) begin
                    tests_failed++;
                    $display("[TB] FAIL single_data: got %0h, expected %0h", rd, ADDR0_INIT);
                end
            end
        end
        tests_run++;
        if (!found || lat != LATENCY) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got %0d (found=%0b), expected %0d", lat, found, LATENCY);
        end
    endtask

    task automatic test_write_read();
        int   n_resp = 0;
        reg_t exp;
        reg_t consts [3] = '{32'd5, 32'd0, 32'd7};
        for (int k = 0; k < 14; k++) begin
            case (k)
                0:       drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 32'd5);
                1:       drive_cycle(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 32'd0);
                2:       drive_cycle(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 32'd7);
                3:       drive_cycle(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 32'd0);
                default: drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
            endcase
            if (popd) begin
                tests_run++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                if (n_resp < 3 && exp !== consts[n_resp]) begin
                    exp = consts[n_resp];
                end
                if (rd !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL write_read_data%0d: got %0h, expected %0h", n_resp, rd, exp);
                end
                n_resp++;
            end
        end
        tests_run++;
        if (n_resp != 3) begin
            tests_failed++;
            $display("[TB] FAIL write_read_count: got %0d, expected 3", n_resp);
        end
    endtask

    task automatic test_back_pressure();
        int   n_acc  = 0;
        int   n_resp = 0;
        reg_t exp;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, memd_addr_t'(8 + i), 32'hA0 + 32'(i));
        end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b1, memd_addr_t'(8 + i), 1'b0, 1'b0, 4'd0, 32'd0);
            if (acc) n_acc++;
        end
        tests_run++;
        if (n_acc != QUEUE_DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL bp_accepts: got %0d, expected %0d", n_acc, QUEUE_DEPTH);
        end
        tests_run++;
        if (rdy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_ready_low: got %0b, expected 0", rdy);
        end
        drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
        tests_run++;
        if (popd !== 1'b1 || rdy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_pop_cycle: got pop=%0b ready=%0b, expected pop=1 ready=0", popd, rdy);
        end
        if (popd) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            tests_run++;
            if (rd !== exp || rd !== 32'hA0) begin
                tests_failed++;
                $display("[TB] FAIL bp_first_data: got %0h, expected a0", rd);
            end
        end
        drive_cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        tests_run++;
        if (rdy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_ready_after_pop: got %0b, expected 1", rdy);
        end
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
            if (popd) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                tests_run++;
                if (rd !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_order%0d: got %0h, expected %0h", n_resp, rd, exp);
                end
                n_resp++;
            end
        end
        tests_run++;
        if (n_resp != QUEUE_DEPTH - 1) begin
            tests_failed++;
            $display("[TB] FAIL bp_drain_count: got %0d, expected %0d", n_resp, QUEUE_DEPTH - 1);
        end
    endtask

    task automatic test_back_to_back();
        int   n_acc     = 0;
        int   n_resp    = 0;
        int   first_acc = -1;
        reg_t exp;
        for (int k = 0; k < 26; k++) begin
            drive_cycle(1'b1, (k < 16), memd_addr_t'(k % 4), 1'b1, 1'b0, 4'd0, 32'd0);
            if (acc) begin
                if (first_acc < 0) first_acc = k;
                n_acc++;
            end
            if (popd) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                tests_run++;
                if (rd !== exp || k != first_acc + LATENCY + n_resp) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_resp%0d: got %0h at cycle %0d, expected %0h at cycle %0d",
                             n_resp, rd, k, exp, first_acc + LATENCY + n_resp);
                end
                n_resp++;
            end
        end
        tests_run++;
        if (n_acc != 16 || n_resp != 16 || first_acc != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_counts: got acc=%0d resp=%0d first=%0d, expected 16 16 0",
                     n_acc, n_resp, first_acc);
        end
    endtask

    task automatic test_reset_mid();
        int   n_acc  = 0;
        int   n_resp = 0;
        reg_t exp;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, memd_addr_t'(i + 1), 1'b0, 1'b0, 4'd0, 32'd0);
        end
        drive_cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
        tests_run++;
        if (rvld !== 1'b0 || rdy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got valid=%0b ready=%0b, expected 0 0", rvld, rdy);
        end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
            tests_run++;
            if (rvld !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midreset_stale%0d: got valid=%0b data=%0h, expected valid=0", k, rvld, rd);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
            if (acc) n_acc++;
        end
        tests_run++;
        if (n_acc != QUEUE_DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL midreset_credits: got %0d, expected %0d", n_acc, QUEUE_DEPTH);
        end
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
            if (popd) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                tests_run++;
                if (rd !== exp || rd !== ADDR0_INIT) begin
                    tests_failed++;
                    $display("[TB] FAIL midreset_data%0d: got %0h, expected %0h", n_resp, rd, ADDR0_INIT);
                end
                n_resp++;
            end
        end
        tests_run++;
        if (n_resp != QUEUE_DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL midreset_drain: got %0d, expected %0d", n_resp, QUEUE_DEPTH);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        model_reset();
        test_reset();
        test_single_load();
        test_write_read();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
